cpu_run_ctrl: RTL and testbench

Run controller and commit-trace buffer that sits directly downstream of the single-cycle CPU core. It drives the core's `global_en` under run, step and stop commands, and detects `ebreak` at fetch so execution stops exactly at the halt instruction. It qualifies the core's registered commit outputs and pushes each retired instruction into a ready/valid trace FIFO for the host debug link.

---
 rtl/cpu_dbg_pkg.sv | 36 +++
 rtl/trace_fifo.sv | 68 ++++++
 rtl/cpu_run_ctrl.sv | 169 ++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_dbg_pkg.sv
// cpu_dbg_pkg
// Shared types and constants for the CPU run controller and its trace FIFO.
//   run_state_t : run-controller state (IDLE=0, RUN=1, STEP=2, HALTED=3)
//   EBREAK_INST : RV32 ebreak encoding snooped on the fetch bus
//   trace_rec_t : one retired-instruction record held in the trace FIFO
// Optional build macro: CPU_RUN_CTRL_TRACE_DMEM_EN adds the data-memory write
// fields (dmem_we / dmem_wa / dmem_wd) to the trace record.
package cpu_dbg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_STEP   = 2'd2,
      ST_HALTED = 2'd3
   } run_state_t;

   localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

   typedef struct packed {
`ifdef CPU_RUN_CTRL_TRACE_DMEM_EN
      logic        dmem_we;
      logic [31:0] dmem_wa;
      logic [31:0] dmem_wd;
`endif
      logic [31:0] pc;
      logic [31:0] inst;
      logic        reg_we;
      logic [4:0]  reg_wa;
      logic [31:0] reg_wd;
   } trace_rec_t;

   function automatic logic is_ebreak(input logic [31:0] inst);
      return (inst == EBREAK_INST);
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo
// First-word fall-through FIFO: the head entry is presented on o_data while
// o_valid is high and leaves on a cycle where i_ready is also high.
// Handshake: a pop happens on a rising edge where o_valid && i_ready; a push
// happens on a rising edge where i_push is high and there is room (or a pop
// frees an entry in the same cycle). o_data reads as zero while empty.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   i_push    : write i_data at the tail
//   i_data    : W-bit record to store
//   o_valid   : head entry present
//   i_ready   : consumer accepts the head
//   o_data    : head entry (zero when empty)
//   o_count   : current occupancy, 0..DEPTH
module trace_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [W-1:0]             i_data,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic [W-1:0]             o_data,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_pop;
   logic          w_push;

   assign w_pop  = (r_count != '0) && i_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_push = i_push && ((r_count != FULL_CNT) || w_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: nothing is read from it while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_valid = (r_count != '0);
   assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
   assign o_count = r_count;

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
// Run controller and commit-trace buffer for the single-cycle CPU core.
// Drives the core clock-enable (global_en) under run/step/stop commands,
// stops exactly at a fetched ebreak, and pushes every qualified commit into
// a trace FIFO read by the host debug link.
// Build macro: CPU_RUN_CTRL_TRACE_DMEM_EN adds trace_dmem_we/wa/wd outputs
// carrying the commit_dmem_* inputs; without it those inputs are unused.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   cmd_run/step/stop     : run (level/pulse), single-step, stop commands
//   fetch_inst            : core fetch word, snooped for ebreak
//   global_en             : core clock-enable
//   commit*               : core's registered commit outputs
//   trace_valid/ready     : trace FIFO head handshake (valid/ready)
//   trace_pc/inst/wd/we/wa: trace FIFO head record
//   state                 : IDLE=0, RUN=1, STEP=2, HALTED=3
//   retired               : count of accepted commits (wraps)
module cpu_run_ctrl
   import cpu_dbg_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_run,
   input  logic             cmd_step,
   input  logic             cmd_stop,
   input  logic [31:0]      fetch_inst,
   output logic             global_en,
   input  logic             commit,
   input  logic             commit_halt,
   input  logic             commit_reg_we,
   input  logic [31:0]      commit_pc,
   input  logic [31:0]      commit_inst,
   input  logic [31:0]      commit_reg_wd,
   input  logic [4:0]       commit_reg_wa,
   input  logic             commit_dmem_we,
   input  logic [31:0]      commit_dmem_wa,
   input  logic [31:0]      commit_dmem_wd,
   output logic             trace_valid,
   input  logic             trace_ready,
   output logic [31:0]      trace_pc,
   output logic [31:0]      trace_inst,
   output logic [31:0]      trace_wd,
   output logic             trace_we,
   output logic [4:0]       trace_wa,
`ifdef CPU_RUN_CTRL_TRACE_DMEM_EN
   output logic             trace_dmem_we,
   output logic [31:0]      trace_dmem_wa,
   output logic [31:0]      trace_dmem_wd,
`endif
   output logic [1:0]       state,
   output logic [CNT_W-1:0] retired
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] OCC_MAX = CW'(FIFO_DEPTH - 1);

   run_state_t       r_state;
   logic             r_en_d;
   logic [CNT_W-1:0] r_retired;

   logic [CW-1:0]    w_count;
   logic [CW-1:0]    w_occ;
   logic             w_space_ok;
   logic             w_active;
   logic             w_global_en;
   logic             w_ebreak;
   logic             w_push;
   logic             w_valid;
   trace_rec_t       w_rec;
   trace_rec_t       w_head;

   // The instruction enabled last cycle commits this cycle and has not yet
   // reached the FIFO, so it reserves an entry. A pop in the same cycle is
   // deliberately not credited, keeping global_en free of trace_ready paths.
   assign w_occ       = w_count + CW'(r_en_d);
   assign w_space_ok  = (w_occ <= OCC_MAX);
   assign w_active    = (r_state == ST_RUN) || (r_state == ST_STEP);
   assign w_global_en = w_active && w_space_ok;
   assign w_ebreak    = w_global_en && is_ebreak(fetch_inst);
   // commit stays high once the core has run, so only en_d marks a fresh one.
   assign w_push      = r_en_d && commit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_en_d  <= 1'b0;
      end else begin
         r_en_d <= w_global_en;
         case (r_state)
            ST_IDLE: begin
               if (!cmd_stop) begin
                  if (cmd_step)     r_state <= ST_STEP;
                  else if (cmd_run) r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_ebreak)      r_state <= ST_HALTED;
               else if (cmd_stop) r_state <= ST_IDLE;
            end
            // Hold in STEP until the single enabled cycle actually happens.
            ST_STEP: begin
               if (w_ebreak)         r_state <= ST_HALTED;
               else if (w_global_en) r_state <= ST_IDLE;
            end
            ST_HALTED: r_state <= ST_HALTED;
            default:   r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         r_retired <= '0;
      else if (w_push) r_retired <= r_retired + CNT_W'(1);
   end

   always_comb begin
      w_rec        = '0;
      w_rec.pc     = commit_pc;
      w_rec.inst   = commit_inst;
      w_rec.reg_we = commit_reg_we;
      w_rec.reg_wa = commit_reg_wa;
      w_rec.reg_wd = commit_reg_wd;
`ifdef CPU_RUN_CTRL_TRACE_DMEM_EN
      w_rec.dmem_we = commit_dmem_we;
      w_rec.dmem_wa = commit_dmem_wa;
      w_rec.dmem_wd = commit_dmem_wd;
`endif
   end

   trace_fifo #(
      .W     ($bits(trace_rec_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_trace_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (w_rec),
      .o_valid (w_valid),
      .i_ready (trace_ready),
      .o_data  (w_head),
      .o_count (w_count)
   );

   assign global_en   = w_global_en;
   assign state       = r_state;
   assign retired     = r_retired;
   assign trace_valid = w_valid;
   assign trace_pc    = w_head.pc;
   assign trace_inst  = w_head.inst;
   assign trace_wd    = w_head.reg_wd;
   assign trace_we    = w_head.reg_we;
   assign trace_wa    = w_head.reg_wa;
`ifdef CPU_RUN_CTRL_TRACE_DMEM_EN
   assign trace_dmem_we = w_head.dmem_we;
   assign trace_dmem_wa = w_head.dmem_wa;
   assign trace_dmem_wd = w_head.dmem_wd;
`else
   logic w_unused_dmem;
   assign w_unused_dmem = ^{commit_dmem_we, commit_dmem_wa, commit_dmem_wd};
`endif

   // Halt is detected at fetch; the core's own halt flag is not needed.
   logic w_unused_halt;
   assign w_unused_halt = commit_halt;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl
// Bench for cpu_run_ctrl: a small behavioural core answers global_en with
// registered commit data, a queue-based reference model predicts state,
// global_en, retired and the trace FIFO contents every cycle, a stimulus
// table covers command sequencing, and directed sequences cover step, halt,
// back-pressure, reset and (with the macro) the dmem record fields.
module tb_cpu_run_ctrl;

   localparam int          DEPTH       = 8;
   localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;
   localparam logic [31:0] ADDI_WORD   = 32'h0010_0093;
   localparam logic [31:0] SW_WORD     = 32'h0011_2023;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] wd;
      logic        we;
      logic [4:0]  wa;
      logic        dwe;
      logic [31:0] dwa;
      logic [31:0] dwd;
   } rec_t;

   typedef struct {
      bit         run;
      bit         step;
      bit         stop;
      logic [1:0] exp_state;
      bit         exp_en;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        cmd_run, cmd_step, cmd_stop;
   logic [31:0] fetch_inst;
   logic        global_en;
   logic        commit, commit_halt, commit_reg_we;
   logic [31:0] commit_pc, commit_inst, commit_reg_wd;
   logic [4:0]  commit_reg_wa;
   logic        commit_dmem_we;
   logic [31:0] commit_dmem_wa, commit_dmem_wd;
   logic        trace_valid, trace_ready;
   logic [31:0] trace_pc, trace_inst, trace_wd;
   logic        trace_we;
   logic [4:0]  trace_wa;
`ifdef CPU_RUN_CTRL_TRACE_DMEM_EN
   logic        trace_dmem_we;
   logic [31:0] trace_dmem_wa, trace_dmem_wd;
`endif
   logic [1:0]  state;
   logic [31:0] retired;

   cpu_run_ctrl #(.FIFO_DEPTH(DEPTH), .CNT_W(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .cmd_run        (cmd_run),
      .cmd_step       (cmd_step),
      .cmd_stop       (cmd_stop),
      .fetch_inst     (fetch_inst),
      .global_en      (global_en),
      .commit         (commit),
      .commit_halt    (commit_halt),
      .commit_reg_we  (commit_reg_we),
      .commit_pc      (commit_pc),
      .commit_inst    (commit_inst),
      .commit_reg_wd  (commit_reg_wd),
      .commit_reg_wa  (commit_reg_wa),
      .commit_dmem_we (commit_dmem_we),
      .commit_dmem_wa (commit_dmem_wa),
      .commit_dmem_wd (commit_dmem_wd),
      .trace_valid    (trace_valid),
      .trace_ready    (trace_ready),
      .trace_pc       (trace_pc),
      .trace_inst     (trace_inst),
      .trace_wd       (trace_wd),
      .trace_we       (trace_we),
      .trace_wa       (trace_wa),
`ifdef CPU_RUN_CTRL_TRACE_DMEM_EN
      .trace_dmem_we  (trace_dmem_we),
      .trace_dmem_wa  (trace_dmem_wa),
      .trace_dmem_wd  (trace_dmem_wd),
`endif
      .state          (state),
      .retired        (retired)
   );

   // ---------------- bench state ----------------
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] prog [256];
   logic [31:0] core_pc;
   int          en_cycles;
   rec_t        got_q[$];

   // reference model: plain queue of records the FIFO should hold
   int          m_state;
   bit          m_en_d;
   int unsigned m_ret;
   rec_t        exp_q[$];

   // ---------------- scoreboard helpers ----------------
   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic bit model_en();
      return ((m_state == 1) || (m_state == 2)) &&
             ((exp_q.size() + int'(m_en_d)) <= DEPTH - 1);
   endfunction

   task automatic check_cycle();
      chk("state", 128'(state), 128'(m_state));
      chk("global_en", 128'(global_en), 128'(model_en()));
      chk("trace_valid", 128'(trace_valid), 128'(exp_q.size() != 0));
      chk("retired", 128'(retired), 128'(m_ret));
      if (exp_q.size() != 0) begin
         chk("trace_pc", 128'(trace_pc), 128'(exp_q[0].pc));
         chk("trace_inst", 128'(trace_inst), 128'(exp_q[0].inst));
         chk("trace_wb", 128'({trace_we, trace_wa, trace_wd}),
             128'({exp_q[0].we, exp_q[0].wa, exp_q[0].wd}));
`ifdef CPU_RUN_CTRL_TRACE_DMEM_EN
         chk("trace_dmem", 128'({trace_dmem_we, trace_dmem_wa, trace_dmem_wd}),
             128'({exp_q[0].dwe, exp_q[0].dwa, exp_q[0].dwd}));
`endif
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst = 1'b1;
      cmd_run = 1'b0; cmd_step = 1'b0; cmd_stop = 1'b0;
      exp_q.delete();
      m_state = 0; m_en_d = 1'b0; m_ret = 0;
      core_pc = 32'h0;
      #1;
      @(posedge clk); #1;
      rst = 1'b0;
      fetch_inst = prog[core_pc[9:2]];
      #1;
   endtask

   // One clock: check, advance the model, clock, let the core respond.
   task automatic tick();
      bit   en_now, e, halt, pop, push;
      int   nxt;
      rec_t r;
      check_cycle();
      en_now = global_en;
      if (en_now) en_cycles++;
      if (trace_valid && trace_ready) begin
         r.pc = trace_pc; r.inst = trace_inst; r.wd = trace_wd;
         r.we = trace_we; r.wa = trace_wa;
         r.dwe = 1'b0; r.dwa = '0; r.dwd = '0;
`ifdef CPU_RUN_CTRL_TRACE_DMEM_EN
         r.dwe = trace_dmem_we; r.dwa = trace_dmem_wa; r.dwd = trace_dmem_wd;
`endif
         got_q.push_back(r);
      end
      // model step
      e    = model_en();
      halt = e && (fetch_inst == EBREAK_WORD);
      pop  = (exp_q.size() != 0) && trace_ready;
      push = m_en_d && commit;
      if (pop) void'(exp_q.pop_front());
      if (push) begin
         r.pc = commit_pc; r.inst = commit_inst; r.wd = commit_reg_wd;
         r.we = commit_reg_we; r.wa = commit_reg_wa;
         r.dwe = commit_dmem_we; r.dwa = commit_dmem_wa; r.dwd = commit_dmem_wd;
         exp_q.push_back(r);
         m_ret++;
      end
      nxt = m_state;
      case (m_state)
         0: if (!cmd_stop) begin
               if (cmd_step)     nxt = 2;
               else if (cmd_run) nxt = 1;
            end
         1: if (halt) nxt = 3; else if (cmd_stop) nxt = 0;
         2: if (halt) nxt = 3; else if (e) nxt = 0;
         default: nxt = 3;
      endcase
      m_state = nxt;
      m_en_d  = e;
      @(posedge clk); #1;
      cmd_run = 1'b0; cmd_step = 1'b0; cmd_stop = 1'b0;
      // behavioural core: registered commit outputs follow each enabled cycle
      if (en_now) begin
         commit        = 1'b1;
         commit_pc     = core_pc;
         commit_inst   = fetch_inst;
         commit_halt   = (fetch_inst == EBREAK_WORD);
         commit_reg_we = 1'($urandom_range(0, 1));
         commit_reg_wa = 5'($urandom_range(0, 31));
         commit_reg_wd = $urandom;
         if (fetch_inst[6:0] == 7'b0100011) begin
            commit_dmem_we = 1'b1;
            commit_dmem_wa = 32'h0000_0100;
            commit_dmem_wd = 32'hDEAD_BEEF;
         end else begin
            commit_dmem_we = 1'b0;
            commit_dmem_wa = $urandom;
            commit_dmem_wd = $urandom;
         end
         core_pc = core_pc + 32'd4;
      end
      fetch_inst = prog[core_pc[9:2]];
      #1;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2_000_000;
      n_fail++;
      $display("FAIL watchdog: got=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   // ---------------- test sequence ----------------
   vec_t vecs [13];

   initial begin
      int guard;
      int bad;

      vecs[0]  = '{run:0, step:0, stop:0, exp_state:2'd0, exp_en:0};
      vecs[1]  = '{run:0, step:0, stop:1, exp_state:2'd0, exp_en:0};
      vecs[2]  = '{run:0, step:1, stop:1, exp_state:2'd0, exp_en:0};
      vecs[3]  = '{run:1, step:0, stop:0, exp_state:2'd1, exp_en:1};
      vecs[4]  = '{run:0, step:1, stop:0, exp_state:2'd1, exp_en:1};
      vecs[5]  = '{run:0, step:0, stop:0, exp_state:2'd1, exp_en:1};
      vecs[6]  = '{run:0, step:1, stop:1, exp_state:2'd0, exp_en:0};
      vecs[7]  = '{run:0, step:1, stop:0, exp_state:2'd2, exp_en:1};
      vecs[8]  = '{run:0, step:0, stop:0, exp_state:2'd0, exp_en:0};
      vecs[9]  = '{run:1, step:1, stop:0, exp_state:2'd2, exp_en:1};
      vecs[10] = '{run:0, step:0, stop:0, exp_state:2'd0, exp_en:0};
      vecs[11] = '{run:1, step:0, stop:0, exp_state:2'd1, exp_en:1};
      vecs[12] = '{run:0, step:0, stop:1, exp_state:2'd0, exp_en:0};

      for (int i = 0; i < 256; i++) prog[i] = ADDI_WORD;
      commit = 1'b0; commit_halt = 1'b0; commit_reg_we = 1'b0;
      commit_pc = '0; commit_inst = '0; commit_reg_wd = '0; commit_reg_wa = '0;
      commit_dmem_we = 1'b0; commit_dmem_wa = '0; commit_dmem_wd = '0;
      trace_ready = 1'b1;
      fetch_inst = ADDI_WORD;
      en_cycles = 0;
      do_reset();

      // reset values
      chk("rst_state", 128'(state), 128'(0));
      chk("rst_global_en", 128'(global_en), 128'(0));
      chk("rst_trace_valid", 128'(trace_valid), 128'(0));
      chk("rst_trace_data", 128'({trace_pc, trace_inst, trace_wd, trace_we, trace_wa}), 128'(0));
      chk("rst_retired", 128'(retired), 128'(0));

      // command sequencing table
      trace_ready = 1'b1;
      for (int i = 0; i < 13; i++) begin
         cmd_run = vecs[i].run; cmd_step = vecs[i].step; cmd_stop = vecs[i].stop;
         tick();
         chk($sformatf("vec%0d_state", i), 128'(state), 128'(vecs[i].exp_state));
         chk($sformatf("vec%0d_en", i), 128'(global_en), 128'(vecs[i].exp_en));
      end
      repeat (4) tick();

      // single step
      do_reset();
      en_cycles = 0; got_q.delete();
      cmd_step = 1'b1;
      tick();
      repeat (6) tick();
      chk("step_en_cycles", 128'(en_cycles), 128'(1));
      chk("step_records", 128'(got_q.size()), 128'(1));
      if (got_q.size() == 1) chk("step_pc", 128'(got_q[0].pc), 128'(32'h0));
      chk("step_retired", 128'(retired), 128'(1));
      chk("step_state", 128'(state), 128'(0));

      // run into ebreak after 20 instructions
      do_reset();
      prog[20] = EBREAK_WORD;
      en_cycles = 0; got_q.delete();
      cmd_run = 1'b1;
      tick();
      guard = 0;
      while (state != 2'd3 && guard < 60) begin tick(); guard++; end
      chk("halt_reached", 128'(guard < 60), 128'(1));
      repeat (3) tick();
      chk("halt_en_cycles", 128'(en_cycles), 128'(21));
      chk("halt_records", 128'(got_q.size()), 128'(21));
      if (got_q.size() == 21) begin
         chk("halt_last_inst", 128'(got_q[20].inst), 128'(EBREAK_WORD));
         chk("halt_last_pc", 128'(got_q[20].pc), 128'(32'd80));
      end
      cmd_run = 1'b1;
      tick();
      chk("halt_ignore_run_state", 128'(state), 128'(3));
      chk("halt_ignore_run_en", 128'(global_en), 128'(0));
      prog[20] = ADDI_WORD;

      // back-pressure: host stalled
      do_reset();
      trace_ready = 1'b0;
      en_cycles = 0; got_q.delete();
      cmd_run = 1'b1;
      tick();
      repeat (20) tick();
      chk("bp_en_cycles", 128'(en_cycles), 128'(DEPTH));
      chk("bp_retired", 128'(retired), 128'(DEPTH));
      chk("bp_valid", 128'(trace_valid), 128'(1));
      trace_ready = 1'b1;
      repeat (30) tick();
      cmd_stop = 1'b1;
      tick();
      repeat (10) tick();
      chk("bp_no_loss", 128'(got_q.size()), 128'(en_cycles));
      chk("bp_progress", 128'(got_q.size() > DEPTH), 128'(1));
      bad = 0;
      foreach (got_q[i]) if (got_q[i].pc != 32'(i * 4)) bad++;
      chk("bp_order", 128'(bad), 128'(0));

      // reset while running with records queued
      do_reset();
      trace_ready = 1'b0;
      cmd_run = 1'b1;
      tick();
      guard = 0;
      while (retired != 32'd3 && guard < 20) begin tick(); guard++; end
      chk("rrun_queued", 128'(retired), 128'(3));
      rst = 1'b1;
      #1;
      chk("rrun_async_valid", 128'(trace_valid), 128'(0));
      chk("rrun_async_retired", 128'(retired), 128'(0));
      chk("rrun_async_en", 128'(global_en), 128'(0));
      do_reset();
      chk("rrun_valid", 128'(trace_valid), 128'(0));
      chk("rrun_retired", 128'(retired), 128'(0));
      chk("rrun_en", 128'(global_en), 128'(0));
      trace_ready = 1'b1;
      repeat (3) tick();
      chk("rrun_discard", 128'(retired), 128'(0));

`ifdef CPU_RUN_CTRL_TRACE_DMEM_EN
      // store commit carries its data-memory write
      do_reset();
      prog[0] = SW_WORD;
      got_q.delete();
      cmd_step = 1'b1;
      tick();
      repeat (5) tick();
      chk("dmem_records", 128'(got_q.size()), 128'(1));
      if (got_q.size() == 1)
         chk("dmem_fields", 128'({got_q[0].dwe, got_q[0].dwa, got_q[0].dwd}),
             128'({1'b1, 32'h0000_0100, 32'hDEAD_BEEF}));
      prog[0] = ADDI_WORD;
`endif

      // randomized traffic against the model
      for (int i = 0; i < 256; i++)
         prog[i] = ($urandom_range(0, 29) == 0) ? EBREAK_WORD : {$urandom_range(0, 33554431), 7'b0010011};
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         if (m_state == 3 && $urandom_range(0, 3) == 0) do_reset();
         else if ($urandom_range(0, 399) == 0) do_reset();
         cmd_run     = ($urandom_range(0, 7) == 0);
         cmd_step    = ($urandom_range(0, 7) == 0);
         cmd_stop    = ($urandom_range(0, 11) == 0);
         trace_ready = ($urandom_range(0, 3) != 0) && (((c / 64) % 3) != 2);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
